// File: rtl/display_serial_rx.sv
// Receiver for the display serial link. It captures a frame of segment bits on ser_clk,
// checks the frame length and decodes each segment byte back to a BCD digit.
// The local clk must run at least 4x faster than ser_clk.
module display_serial_rx #(
  parameter int unsigned FRAME_BITS     = 32,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        ser_clk,
  input  logic        data_in,
  input  logic        sending_data,
  output logic [31:0] segments_out,
  output logic [15:0] bcd_out,
  output logic [3:0]  digit_error,
  output logic        data_valid,
  output logic        frame_error,
  output logic        busy
);

  localparam int unsigned CntW = $clog2(FRAME_BITS + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    StIdle,
    StReceive,
    StDone
  } state_e;

  // Synchronizer chains; bit [SYNC_STAGES-1] is the synchronized copy.
  logic [SYNC_STAGES-1:0] ser_sync_q, ser_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
  logic [SYNC_STAGES-1:0] sd_sync_q,  sd_sync_d;

  // Edge detection history of the synchronized copies.
  logic ser_prev_q, ser_prev_d;
  logic sd_prev_q,  sd_prev_d;

  // Fills with ones after reset; once the top bit is set the sync chains hold real pin values.
  logic [SYNC_STAGES:0] fill_q, fill_d;
  // Set once the strobe has been seen low, so a strobe already high out of reset is ignored.
  logic armed_q, armed_d;

  state_e            state_q, state_d;
  logic [31:0]       shift_q, shift_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [31:0]       seg_q, seg_d;
  logic [15:0]       bcd_q, bcd_d;
  logic [3:0]        derr_q, derr_d;
  logic              dv_q, dv_d;
  logic              fe_q, fe_d;

  logic ser_s, dat_s, sd_s;
  logic ser_fall, sd_rise, sd_fall;
  logic sample;
  logic [CntW-1:0] cnt_eff;

  // Inverse of the bcd2segments table: {error, digit}; unknown bytes give {1, 4'hF}.
  function automatic logic [4:0] seg_to_bcd(input logic [7:0] seg);
    logic [4:0] res;
    case (seg)
      8'h3F:   res = 5'h00;
      8'h06:   res = 5'h01;
      8'h5B:   res = 5'h02;
      8'h4F:   res = 5'h03;
      8'h66:   res = 5'h04;
      8'h6D:   res = 5'h05;
      8'h7D:   res = 5'h06;
      8'h07:   res = 5'h07;
      8'h7F:   res = 5'h08;
      8'h6F:   res = 5'h09;
      default: res = 5'h1F;
    endcase
    return res;
  endfunction

  // Next state of the synchronizer chains and the post-reset fill tracker.
  always_comb begin
    ser_sync_d    = ser_sync_q;
    dat_sync_d    = dat_sync_q;
    sd_sync_d     = sd_sync_q;
    ser_sync_d[0] = ser_clk;
    dat_sync_d[0] = data_in;
    sd_sync_d[0]  = sending_data;
    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
      ser_sync_d[i] = ser_sync_q[i-1];
      dat_sync_d[i] = dat_sync_q[i-1];
      sd_sync_d[i]  = sd_sync_q[i-1];
    end
    fill_d = {fill_q[SYNC_STAGES-1:0], 1'b1};
  end

  assign ser_s = ser_sync_q[SYNC_STAGES-1];
  assign dat_s = dat_sync_q[SYNC_STAGES-1];
  assign sd_s  = sd_sync_q[SYNC_STAGES-1];

  assign ser_prev_d = ser_s;
  assign sd_prev_d  = sd_s;
  assign armed_d    = armed_q | (fill_q[SYNC_STAGES] & ~sd_s);

  assign ser_fall = ser_prev_q & ~ser_s;
  assign sd_rise  = armed_q & ~sd_prev_q & sd_s;
  assign sd_fall  = sd_prev_q & ~sd_s;

  // Frame FSM: capture, length and timeout checks, decode and output update.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    seg_d   = seg_q;
    bcd_d   = bcd_q;
    derr_d  = derr_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
    sample  = 1'b0;
    cnt_eff = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (enable && sd_rise) begin
          state_d = StReceive;
          shift_d = '0;
          cnt_d   = '0;
          tmo_d   = '0;
        end
      end

      StReceive: begin
        // Strobe history is used so a bit landing with the strobe fall is still taken.
        sample = ser_fall & sd_prev_q;
        if (sample) begin
          shift_d = {dat_s, shift_q[31:1]};
          cnt_eff = cnt_q + 1'b1;
        end
        cnt_d = cnt_eff;
        tmo_d = ser_fall ? '0 : tmo_q + 1'b1;

        if (sample && (cnt_q == CntW'(FRAME_BITS))) begin
          state_d = StIdle;
          fe_d    = 1'b1;
        end else if (sd_fall) begin
          if (cnt_eff == CntW'(FRAME_BITS)) begin
            state_d = StDone;
          end else begin
            state_d = StIdle;
            fe_d    = 1'b1;
          end
        end else if (!ser_fall && (tmo_q == TmoW'(TIMEOUT_CYCLES - 1))) begin
          state_d = StIdle;
          fe_d    = 1'b1;
        end
      end

      StDone: begin
        seg_d = shift_q;
        for (int k = 0; k < 4; k++) begin
          {derr_d[k], bcd_d[4*k +: 4]} = seg_to_bcd(shift_q[8*k +: 8]);
        end
        dv_d    = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ser_sync_q <= '0;
      dat_sync_q <= '0;
      sd_sync_q  <= '0;
      ser_prev_q <= 1'b0;
      sd_prev_q  <= 1'b0;
      fill_q     <= '0;
      armed_q    <= 1'b0;
      state_q    <= StIdle;
      shift_q    <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      seg_q      <= '0;
      bcd_q      <= '0;
      derr_q     <= '0;
      dv_q       <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      ser_sync_q <= ser_sync_d;
      dat_sync_q <= dat_sync_d;
      sd_sync_q  <= sd_sync_d;
      ser_prev_q <= ser_prev_d;
      sd_prev_q  <= sd_prev_d;
      fill_q     <= fill_d;
      armed_q    <= armed_d;
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      seg_q      <= seg_d;
      bcd_q      <= bcd_d;
      derr_q     <= derr_d;
      dv_q       <= dv_d;
      fe_q       <= fe_d;
    end
  end

  assign segments_out = seg_q;
  assign bcd_out      = bcd_q;
  assign digit_error  = derr_q;
  assign data_valid   = dv_q;
  assign frame_error  = fe_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_display_serial_rx.sv
// Directed bench for display_serial_rx with a scoreboard of expected decoded frames.
module tb_display_serial_rx;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        ser_clk = 1'b0;
  logic        data_in = 1'b0;
  logic        sending_data = 1'b0;
  logic [31:0] segments_out;
  logic [15:0] bcd_out;
  logic [3:0]  digit_error;
  logic        data_valid;
  logic        frame_error;
  logic        busy;

  display_serial_rx dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .ser_clk      (ser_clk),
    .data_in      (data_in),
    .sending_data (sending_data),
    .segments_out (segments_out),
    .bcd_out      (bcd_out),
    .digit_error  (digit_error),
    .data_valid   (data_valid),
    .frame_error  (frame_error),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] seg;
    logic [15:0] bcd;
    logic [3:0]  derr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   dv_cnt = 0;
  int   fe_cnt = 0;
  int   fe_cyc = 0;
  int   fall_cyc = -1;
  int   last_ser_fall_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] enc_digit(input logic [3:0] d);
    case (d)
      4'd0: return 8'h3F;
      4'd1: return 8'h06;
      4'd2: return 8'h5B;
      4'd3: return 8'h4F;
      4'd4: return 8'h66;
      4'd5: return 8'h6D;
      4'd6: return 8'h7D;
      4'd7: return 8'h07;
      4'd8: return 8'h7F;
      4'd9: return 8'h6F;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] enc_frame(input logic [15:0] bcd);
    logic [31:0] f;
    for (int k = 0; k < 4; k++) f[8*k +: 8] = enc_digit(bcd[4*k +: 4]);
    return f;
  endfunction

  // Transmitter: data and strobe change with ser_clk rising; stop_after < nbits leaves
  // ser_clk parked low and the strobe high after that many bits.
  task automatic send_frame(input logic [31:0] bits, input int nbits, input int stop_after);
    @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == stop_after) return;
      ser_clk      = 1'b1;
      data_in      = bits[i % 32];
      sending_data = 1'b1;
      #40;
      ser_clk           = 1'b0;
      last_ser_fall_cyc = cyc;
      #40;
    end
    ser_clk      = 1'b1;
    sending_data = 1'b0;
    fall_cyc     = cyc;
    #40;
    ser_clk = 1'b0;
    #40;
  endtask

  // Bounded wait for a pulse counter (0: data_valid, 1: frame_error) to reach target.
  task automatic wait_count(input string tag, input int which, input int target,
                            input int budget);
    int n = 0;
    while (((which == 0) ? dv_cnt : fe_cnt) < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    #2;
    check(tag, (which == 0) ? dv_cnt : fe_cnt, target);
  endtask

  task automatic check_outputs(input string tag, input logic [15:0] bcd);
    check({tag, "_bcd"}, bcd_out, bcd);
    check({tag, "_seg"}, segments_out, enc_frame(bcd));
    check({tag, "_derr"}, digit_error, 4'h0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output monitor: scoreboard pop on data_valid, frame_error bookkeeping.
  initial forever begin
    @(negedge clk);
    if (data_valid) begin
      exp_t e;
      dv_cnt++;
      check("dv_fe_excl", {31'd0, frame_error}, 32'd0);
      check("latency", cyc - fall_cyc, 4);
      check("sb_pending", sb.size(), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_bcd", bcd_out, e.bcd);
        check("sb_seg", segments_out, e.seg);
        check("sb_derr", digit_error, e.derr);
      end
    end
    if (frame_error) begin
      fe_cnt++;
      fe_cyc = cyc;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] f;
    int d;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_seg", segments_out, 32'h0);
    check("rst_bcd", bcd_out, 16'h0);
    check("rst_flags", {digit_error, data_valid, frame_error, busy}, 7'h0);
    reset = 1'b1;
    enable = 1'b1;
    repeat (5) @(negedge clk);

    // Loopback 1234
    sb.push_back('{seg: enc_frame(16'h1234), bcd: 16'h1234, derr: 4'h0});
    send_frame(enc_frame(16'h1234), 32, 32);
    wait_count("t1_dv", 0, 1, 200);
    check_outputs("t1", 16'h1234);
    check("t1_fe", fe_cnt, 0);
    check("t1_busy", {31'd0, busy}, 32'd0);

    // Back-to-back 0000 then 9876 with a 160-period gap
    sb.push_back('{seg: enc_frame(16'h0000), bcd: 16'h0000, derr: 4'h0});
    send_frame(enc_frame(16'h0000), 32, 32);
    repeat (160 * 8) @(negedge clk);
    sb.push_back('{seg: enc_frame(16'h9876), bcd: 16'h9876, derr: 4'h0});
    send_frame(enc_frame(16'h9876), 32, 32);
    wait_count("t2_dv", 0, 3, 200);
    check_outputs("t2", 16'h9876);

    // Short and long strobes
    send_frame(enc_frame(16'h1111), 31, 31);
    wait_count("t3s_fe", 1, 1, 200);
    check_outputs("t3s", 16'h9876);
    check("t3s_busy", {31'd0, busy}, 32'd0);
    send_frame(enc_frame(16'h2222), 33, 33);
    wait_count("t3l_fe", 1, 2, 200);
    check_outputs("t3l", 16'h9876);
    check("t3l_busy", {31'd0, busy}, 32'd0);
    check("t3_dv", dv_cnt, 3);

    // Frame while disabled is ignored without error
    enable = 1'b0;
    send_frame(enc_frame(16'h4444), 32, 32);
    enable = 1'b1;
    repeat (30) @(negedge clk);
    check("dis_dv", dv_cnt, 3);
    check("dis_fe", fe_cnt, 2);
    check("dis_bcd", bcd_out, 16'h9876);

    // Invalid segment byte in digit 2
    f = enc_frame(16'h4321);
    f[23:16] = 8'h00;
    sb.push_back('{seg: f, bcd: 16'h4F21, derr: 4'b0100});
    send_frame(f, 32, 32);
    wait_count("t4_dv", 0, 4, 200);
    check("t4_derr", digit_error, 4'b0100);
    check("t4_bcd", bcd_out, 16'h4F21);

    // ser_clk stopped after bit 10
    send_frame(enc_frame(16'h7777), 32, 10);
    repeat (500) @(negedge clk);
    check("t5_busy_mid", {31'd0, busy}, 32'd1);
    check("t5_no_early_fe", fe_cnt, 2);
    wait_count("t5_fe", 1, 3, 1200);
    d = fe_cyc - last_ser_fall_cyc;
    check("t5_tmo_window", {31'd0, (d >= 1024 && d <= 1030)}, 32'd1);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_bcd", bcd_out, 16'h4F21);
    @(negedge clk);
    sending_data = 1'b0;
    repeat (20) @(negedge clk);

    // Reset mid-frame at bit 20
    send_frame(enc_frame(16'h8888), 32, 20);
    reset = 1'b0;
    #1;
    check("t6_rst_seg", segments_out, 32'h0);
    check("t6_rst_bcd", bcd_out, 16'h0);
    check("t6_rst_flags", {digit_error, data_valid, frame_error, busy}, 7'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    sending_data = 1'b0;
    repeat (30) @(negedge clk);
    check("t6_no_dv", dv_cnt, 4);
    check("t6_no_fe", fe_cnt, 3);
    sb.push_back('{seg: enc_frame(16'h5555), bcd: 16'h5555, derr: 4'h0});
    send_frame(enc_frame(16'h5555), 32, 32);
    wait_count("t6_dv", 0, 5, 200);
    check_outputs("t6", 16'h5555);
    check("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
